comm_responder: RTL and testbench

- Remote end of the three-byte command link: deserializes frames from the command master and presents them as one cmd/data pair.
- Serializes a one-byte response back to the master on the return line.
- Sits between the serial pins and the command-processing logic; pairs with the existing command master across RX/TX.
- Frame format: cmd byte, then data[15:8], then data[7:0]. Each byte is 8N1, LSB first, idle-high line.

---
 rtl/comm_responder_pkg.sv | 25 ++
 rtl/comm_uart_trx.sv | 181 ++++++++++++++++++
 rtl/comm_responder.sv | 129 ++++++++++++
 tb/tb_comm_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_responder_pkg.sv
// Shared types and constants for the three-byte command link responder.
package comm_responder_pkg;

  localparam int unsigned FRAME_BYTES   = 3;
  localparam int unsigned BITS_PER_BYTE = 10;

  typedef enum logic [1:0] {
    IDLE,
    GOT_CMD,
    GOT_HI
  } frm_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/comm_uart_trx.sv
// Byte-level 8N1 receiver and transmitter, LSB first, idle-high line.
module comm_uart_trx
  import comm_responder_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_busy,
  output logic       rx_start_ok,
  output logic       rx_done,
  output logic       rx_err,
  output logic [7:0] rx_byte,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_done
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]       TX_LAST   = 4'(BITS_PER_BYTE - 1);

  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_done_q, rx_done_d, rx_err_q, rx_err_d;
  logic             rx_start_ok_q, rx_start_ok_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_sh_q, tx_sh_d;
  logic             tx_q, tx_d, tx_done_q, tx_done_d;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_s1_d       = rx;
    rx_s2_d       = rx_s1_q;
    rx_prev_d     = rx_s2_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_done_d     = 1'b0;
    rx_err_d      = 1'b0;
    rx_start_ok_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit is a glitch, not an error.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_state_d    = RX_DATA;
            rx_bit_d      = '0;
            rx_start_ok_d = 1'b1;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          if (rx_s2_q) rx_done_d = 1'b1;
          else         rx_err_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_d = TX_SHIFT;
          tx_sh_d    = {1'b1, tx_byte};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_SHIFT: begin
        // Shifting in ones leaves the stop bit in place after the last data bit.
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == TX_LAST) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_sh_q       <= '0;
      rx_done_q     <= 1'b0;
      rx_err_q      <= 1'b0;
      rx_start_ok_q <= 1'b0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_sh_q       <= '1;
      tx_q          <= 1'b1;
      tx_done_q     <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_prev_q     <= rx_prev_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_sh_q       <= rx_sh_d;
      rx_done_q     <= rx_done_d;
      rx_err_q      <= rx_err_d;
      rx_start_ok_q <= rx_start_ok_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_sh_q       <= tx_sh_d;
      tx_q          <= tx_d;
      tx_done_q     <= tx_done_d;
    end
  end

  assign rx_busy     = (rx_state_q != RX_IDLE);
  assign rx_start_ok = rx_start_ok_q;
  assign rx_done     = rx_done_q;
  assign rx_err      = rx_err_q;
  assign rx_byte     = rx_sh_q;
  assign tx          = tx_q;
  assign tx_done     = tx_done_q;

endmodule

// File: rtl/comm_responder.sv
// Remote end of the command link: assembles cmd/data frames from RX and
// serialises a one-byte response on TX.
module comm_responder
  import comm_responder_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic       rx_busy, rx_start_ok, rx_done, rx_err;
  logic [7:0] rx_byte;

  frm_state_e      state_q, state_d;
  logic [7:0]      shadow_q [FRAME_BYTES-1];
  logic [7:0]      shadow_d [FRAME_BYTES-1];
  logic [7:0]      cmd_q, cmd_d;
  logic [15:0]     data_q, data_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frm_err_q, frm_err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            frame_done;

  comm_uart_trx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_trx (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .tx         (TX),
    .rx_busy    (rx_busy),
    .rx_start_ok(rx_start_ok),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .rx_byte    (rx_byte),
    .tx_byte    (resp),
    .tx_start   (snd_resp),
    .tx_done    (resp_sent)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    frm_err_d  = 1'b0;
    frame_done = 1'b0;
    if (rx_err) begin
      state_d   = IDLE;
      frm_err_d = 1'b1;
    end else if (rx_done) begin
      case (state_q)
        IDLE: begin
          shadow_d[0] = rx_byte;
          state_d     = GOT_CMD;
        end
        GOT_CMD: begin
          shadow_d[1] = rx_byte;
          state_d     = GOT_HI;
        end
        GOT_HI: begin
          cmd_d      = shadow_q[0];
          data_d     = {shadow_q[1], rx_byte};
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && !rx_busy && to_cnt_q == TO_LAST) begin
      state_d   = IDLE;
      frm_err_d = 1'b1;
    end
  end

  // Gap timer measures idle line time only; any byte activity restarts it.
  always_comb begin
    if (state_q == IDLE || rx_busy || rx_done || rx_err) to_cnt_d = '0;
    else                                                 to_cnt_d = to_cnt_q + 1'b1;
  end

  // A completing frame outranks a same-cycle acknowledge.
  always_comb begin
    cmd_rdy_d = cmd_rdy_q;
    if (frame_done)                                         cmd_rdy_d = 1'b1;
    else if (clr_cmd_rdy || (rx_start_ok && state_q == IDLE)) cmd_rdy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '{default: '0};
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_comm_responder.sv
// Directed bench for comm_responder with BAUD_DIV=16, TIMEOUT_BITS=20.
module tb_comm_responder;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, snd_resp, resp_sent, frm_err;
  logic [7:0]  cmd, resp;
  logic [15:0] data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned frm_err_cnt = 0;
  int unsigned resp_sent_cnt = 0;

  comm_responder #(
    .BAUD_DIV    (16),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .data       (data),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .snd_resp   (snd_resp),
    .resp_sent  (resp_sent),
    .frm_err    (frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_err === 1'b1) frm_err_cnt++;
    if (resp_sent === 1'b1) resp_sent_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_data(b);
    RX = stop;
    tick(BD);
    RX = 1'b1;
  endtask

  // Stop bit of the last byte is driven for one full bit; cmd_rdy is sampled
  // 4 clks in (before the mid-bit stop sample) and again at the end of the bit.
  // With clr_at_done, clr_cmd_rdy is sampled on the edge that sets cmd_rdy:
  // 2-flop sync + edge reg put the stop sample on edge 155 of the byte, and
  // cmd_rdy sets on edge 156, i.e. 12 edges after the stop bit is driven.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input logic clr_at_done, output logic early_rdy);
    send_byte(c, 1'b1);
    send_byte(hi, 1'b1);
    send_data(lo);
    RX = 1'b1;
    tick(4);
    early_rdy = cmd_rdy;
    if (clr_at_done) begin
      tick(7);
      clr_cmd_rdy = 1'b1;
      tick(1);
      clr_cmd_rdy = 1'b0;
      tick(4);
    end else begin
      tick(12);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; snd_resp = 1'b0; resp = 8'h00;
    #1;
    vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", TX); end
    vectors++; if (cmd !== 8'h00) begin miscompares++; $display("FAIL reset_cmd: got %h want 00", cmd); end
    vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", data); end
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", cmd_rdy); end
    vectors++; if (resp_sent !== 1'b0) begin miscompares++; $display("FAIL reset_sent: got %b want 0", resp_sent); end
    vectors++; if (frm_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", frm_err); end
    tick(3);
    rst = 1'b0;
    tick(20);
  endtask

  task automatic test_basic;
    logic early;
    send_frame(8'h20, 8'h00, 8'h60, 1'b0, early);
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL basic_early_rdy: got %b want 0", early); end
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL basic_rdy: got %b want 1", cmd_rdy); end
    vectors++; if (cmd !== 8'h20) begin miscompares++; $display("FAIL basic_cmd: got %h want 20", cmd); end
    vectors++; if (data !== 16'h0060) begin miscompares++; $display("FAIL basic_data: got %h want 0060", data); end
    vectors++; if (frm_err_cnt !== 0) begin miscompares++; $display("FAIL basic_no_err: got %0d want 0", frm_err_cnt); end
  endtask

  task automatic test_clr;
    logic early;
    send_frame(8'hFF, 8'hFF, 8'hFF, 1'b0, early);
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL clr_set: got %b want 1", cmd_rdy); end
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL clr_cleared: got %b want 0", cmd_rdy); end
    vectors++; if (cmd !== 8'hFF) begin miscompares++; $display("FAIL clr_cmd_hold: got %h want FF", cmd); end
    vectors++; if (data !== 16'hFFFF) begin miscompares++; $display("FAIL clr_data_hold: got %h want FFFF", data); end
    tick(8);
    send_frame(8'h12, 8'h34, 8'h56, 1'b1, early);
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL clr_set_wins: got %b want 1", cmd_rdy); end
    vectors++; if (cmd !== 8'h12) begin miscompares++; $display("FAIL clr2_cmd: got %h want 12", cmd); end
    vectors++; if (data !== 16'h3456) begin miscompares++; $display("FAIL clr2_data: got %h want 3456", data); end
    tick(8);
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL clr_set_holds: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_timeout;
    int unsigned e0;
    logic early;
    e0 = frm_err_cnt;
    send_byte(8'h43, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(300);
    vectors++; if (frm_err_cnt !== e0) begin miscompares++; $display("FAIL to_early: got %0d want %0d", frm_err_cnt, e0); end
    tick(100);
    vectors++; if (frm_err_cnt !== e0 + 1) begin miscompares++; $display("FAIL to_err: got %0d want %0d", frm_err_cnt, e0 + 1); end
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL to_rdy: got %b want 0", cmd_rdy); end
    vectors++; if (cmd !== 8'h12) begin miscompares++; $display("FAIL to_cmd_hold: got %h want 12", cmd); end
    vectors++; if (data !== 16'h3456) begin miscompares++; $display("FAIL to_data_hold: got %h want 3456", data); end
    send_frame(8'h93, 8'h04, 8'h21, 1'b0, early);
    vectors++; if (cmd !== 8'h93) begin miscompares++; $display("FAIL to_next_cmd: got %h want 93", cmd); end
    vectors++; if (data !== 16'h0421) begin miscompares++; $display("FAIL to_next_data: got %h want 0421", data); end
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL to_next_rdy: got %b want 1", cmd_rdy); end
    vectors++; if (frm_err_cnt !== e0 + 1) begin miscompares++; $display("FAIL to_next_err: got %0d want %0d", frm_err_cnt, e0 + 1); end
  endtask

  task automatic test_stop_err;
    int unsigned e0;
    logic early;
    e0 = frm_err_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h76, 1'b0);
    tick(BD);
    vectors++; if (frm_err_cnt !== e0 + 1) begin miscompares++; $display("FAIL stop_err: got %0d want %0d", frm_err_cnt, e0 + 1); end
    send_frame(8'h43, 8'h00, 8'h76, 1'b0, early);
    vectors++; if (cmd !== 8'h43) begin miscompares++; $display("FAIL stop_next_cmd: got %h want 43", cmd); end
    vectors++; if (data !== 16'h0076) begin miscompares++; $display("FAIL stop_next_data: got %h want 0076", data); end
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL stop_next_rdy: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_glitch;
    int unsigned e0;
    logic early;
    e0 = frm_err_cnt;
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(40);
    send_frame(8'h3C, 8'h5A, 8'h0F, 1'b0, early);
    vectors++; if (cmd !== 8'h3C) begin miscompares++; $display("FAIL glitch_cmd: got %h want 3C", cmd); end
    vectors++; if (data !== 16'h5A0F) begin miscompares++; $display("FAIL glitch_data: got %h want 5A0F", data); end
    vectors++; if (frm_err_cnt !== e0) begin miscompares++; $display("FAIL glitch_err: got %0d want %0d", frm_err_cnt, e0); end
  endtask

  task automatic test_tx;
    int unsigned s0;
    logic [9:0] txexp;
    txexp = {1'b1, 8'hA5, 1'b0};
    tick(5);
    s0 = resp_sent_cnt;
    vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL tx_idle: got %b want 1", TX); end
    resp = 8'hA5;
    snd_resp = 1'b1;
    for (int t = 1; t <= 170; t++) begin
      tick(1);
      if (t == 1) begin
        snd_resp = 1'b0;
        vectors++; if (TX !== 1'b0) begin miscompares++; $display("FAIL tx_start_edge: got %b want 0", TX); end
      end
      if (t == 50) begin resp = 8'h3C; snd_resp = 1'b1; end
      if (t == 51) snd_resp = 1'b0;
      if (t % 16 == 9 && t < 160) begin
        vectors++;
        if (TX !== txexp[t / 16]) begin
          miscompares++; $display("FAIL tx_bit%0d: got %b want %b", t / 16, TX, txexp[t / 16]);
        end
      end
      if (t == 160) begin
        vectors++; if (resp_sent !== 1'b0) begin miscompares++; $display("FAIL tx_sent_early: got %b want 0", resp_sent); end
      end
      if (t == 161) begin
        vectors++; if (resp_sent !== 1'b1) begin miscompares++; $display("FAIL tx_sent_161: got %b want 1", resp_sent); end
        vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL tx_end_idle: got %b want 1", TX); end
      end
      if (t == 162) begin
        vectors++; if (resp_sent !== 1'b0) begin miscompares++; $display("FAIL tx_sent_width: got %b want 0", resp_sent); end
      end
    end
    vectors++; if (resp_sent_cnt !== s0 + 1) begin miscompares++; $display("FAIL tx_sent_count: got %0d want %0d", resp_sent_cnt, s0 + 1); end
  endtask

  task automatic test_reset_mid;
    int unsigned e0, s0;
    logic early;
    send_byte(8'h20, 1'b1);
    RX = 1'b0;
    tick(BD);
    tick(5);
    resp = 8'h00;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    tick(3);
    vectors++; if (TX !== 1'b0) begin miscompares++; $display("FAIL rstm_tx_busy: got %b want 0", TX); end
    e0 = frm_err_cnt;
    s0 = resp_sent_cnt;
    rst = 1'b1;
    RX = 1'b1;
    #1;
    vectors++; if (TX !== 1'b1) begin miscompares++; $display("FAIL rstm_tx: got %b want 1", TX); end
    vectors++; if (cmd !== 8'h00) begin miscompares++; $display("FAIL rstm_cmd: got %h want 00", cmd); end
    vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL rstm_data: got %h want 0000", data); end
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL rstm_rdy: got %b want 0", cmd_rdy); end
    tick(3);
    rst = 1'b0;
    tick(200);
    vectors++; if (resp_sent_cnt !== s0) begin miscompares++; $display("FAIL rstm_no_sent: got %0d want %0d", resp_sent_cnt, s0); end
    send_frame(8'h20, 8'h00, 8'h60, 1'b0, early);
    vectors++; if (cmd !== 8'h20) begin miscompares++; $display("FAIL rstm_cmd2: got %h want 20", cmd); end
    vectors++; if (data !== 16'h0060) begin miscompares++; $display("FAIL rstm_data2: got %h want 0060", data); end
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL rstm_rdy2: got %b want 1", cmd_rdy); end
    vectors++; if (frm_err_cnt !== e0) begin miscompares++; $display("FAIL rstm_no_err: got %0d want %0d", frm_err_cnt, e0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clr;
    test_timeout;
    test_stop_err;
    test_glitch;
    test_tx;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
